regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Reader/serializer for the 16-byte register file: snapshots the latched registers, walks read addresses 0..15 and streams each byte out on a byte-wide valid/ready master port.
- Sits between the register file and the host-side transmit path (UART/stream TX) and provides configuration read-back.
- Bytes 0..7 are the compile-time gate-time defaults; bytes 8..15 are the most recently written configuration.

Parameters:
- BYTE_CNT, 16, number of register bytes dumped (addresses 0..BYTE_CNT-1)
- ADDR_WIDTH, 4, width of reg_rd_addr_o; BYTE_CNT <= 2**ADDR_WIDTH

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- dump_start_i  input  1  single-cycle request to start a dump
- dump_busy_o  output  1  high from accepted start until the last byte handshakes
- dump_done_o  output  1  one-cycle pulse on the cycle after the last byte handshakes
- reg_rd_en_o  output  1  snapshot strobe to the register file (latches regs into bytes 8..15)
- reg_rd_addr_o  output  ADDR_WIDTH  register file read address
- reg_rd_data_i  input  8  register file read data, combinational from reg_rd_addr_o
- m_data_o  output  8  stream byte
- m_valid_o  output  1  stream byte valid
- m_last_o  output  1  marks the final byte of a dump
- m_ready_i  input  1  downstream ready

Behaviour:
- Clock clk_i; reset rst_n_i is asynchronous and active-low. All outputs are registered or decoded from registered state.
- Reset values: state IDLE, addr counter 0, reg_rd_addr_o=0, reg_rd_en_o=0, m_valid_o=0, m_last_o=0, m_data_o=8'h00, dump_busy_o=0, dump_done_o=0.
- FSM states: IDLE, SNAP, SEND, DRAIN.
- IDLE:
  - dump_start_i=1 -> SNAP; dump_busy_o rises the next cycle.
  - dump_start_i while not IDLE is ignored; no queueing.
- SNAP:
  - Exactly one cycle with reg_rd_en_o=1, addr counter cleared to 0; then -> SEND.
  - Register file bytes 8..15 are valid from the first SEND cycle.
- SEND:
  - reg_rd_addr_o = addr counter.
  - Load condition: !m_valid_o || m_ready_i. When it holds, register m_data_o <= reg_rd_data_i, set m_valid_o=1, set m_last_o=(addr==BYTE_CNT-1), and increment addr.
  - After loading the last byte -> DRAIN.
- DRAIN:
  - Hold m_data_o/m_valid_o/m_last_o until m_ready_i=1.
  - On that handshake: m_valid_o=0, m_last_o=0, dump_busy_o=0, pulse dump_done_o next cycle; -> IDLE.
- Handshake rules:
  - A byte transfers on a cycle with m_valid_o && m_ready_i.
  - While m_valid_o && !m_ready_i, m_data_o and m_last_o are stable.
  - With m_ready_i held high: one byte per cycle, no bubbles. Total dump = 1 SNAP cycle + BYTE_CNT transfer cycles; first byte valid 2 cycles after start.
- Latency: start at cycle 0 -> reg_rd_en_o at cycle 1 -> first m_valid_o at cycle 2.
- Counter width: ADDR_WIDTH+1 bits internally; no wrap within a dump.
- Bytes are emitted in address order 0..BYTE_CNT-1; byte n = register file byte n.
- Register file writes during a dump do not affect bytes 8..15: the snapshot taken in SNAP is what is sent.
- Reset mid-dump: returns immediately to reset values. No partial m_last_o and no dump_done_o pulse.

Optional Feature:
- Macro: REGFILE_DUMP_CKSUM_EN.
- Defined:
  - After byte BYTE_CNT-1, one extra byte is emitted: the 8-bit sum (mod 256) of all dumped bytes.
  - m_last_o is on the checksum byte only; the dump is BYTE_CNT+1 bytes.
  - The accumulator clears in SNAP and adds each byte when it is loaded into m_data_o.
- Undefined: no accumulator; m_last_o is on byte BYTE_CNT-1.

Test Plan:
- Write reg_wr_data=64'h0807060504030201, then start with m_ready_i=1 -> reg_rd_en_o pulse at cycle 1; 16 back-to-back bytes: defaults for bytes 0..7, then 01,02,...,08; m_last_o on byte 15 only; dump_done_o one cycle after.
- Same dump with m_ready_i toggling 1,0,0,1,... -> byte sequence unchanged; m_data_o stable during every stall; no byte dropped or duplicated.
- dump_start_i pulsed again at cycles 3 and 10 of an active dump -> ignored; exactly 16 bytes and one dump_done_o.
- Register file rewritten with 64'hFFFF...FF during SEND -> bytes 8..15 still 01..08; a second dump returns FF x8.
- rst_n_i asserted after 5 bytes -> all outputs return to reset values asynchronously; a new start produces a complete 16-byte dump from address 0.
- REGFILE_DUMP_CKSUM_EN defined, all defaults zero, regs 01..08 -> 17th byte 8'h24 with m_last_o=1; byte 15 has m_last_o=0.

Source files
------------

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// regfile_dump : snapshots the register file and streams bytes 0..BYTE_CNT-1
//                on a valid/ready byte port. Optional REGFILE_DUMP_CKSUM_EN
//                appends a mod-256 checksum byte.           Revision: 1.0
// ============================================================================
module regfile_dump #(
    parameter int BYTE_CNT   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  dump_start_i,
    output logic                  dump_busy_o,
    output logic                  dump_done_o,
    output logic                  reg_rd_en_o,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr_o,
    input  logic [7:0]            reg_rd_data_i,
    output logic [7:0]            m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SNAP  = 2'd1,
        S_SEND  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int CW = ADDR_WIDTH + 1;
`ifdef REGFILE_DUMP_CKSUM_EN
    localparam logic [CW-1:0] C_FINAL = CW'(BYTE_CNT);
`else
    localparam logic [CW-1:0] C_FINAL = CW'(BYTE_CNT - 1);
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_addr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_done;
    logic          w_load;
    logic          w_final;
    logic [7:0]    w_byte;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = !r_valid || m_ready_i;
        w_final     = (r_addr == C_FINAL);
        case (r_state)
            S_IDLE:  if (dump_start_i) w_state_nxt = S_SNAP;
            S_SNAP:  w_state_nxt = w_final ? S_DRAIN : S_SEND;
            S_SEND:  if (w_load && w_final) w_state_nxt = S_DRAIN;
            S_DRAIN: if (m_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef REGFILE_DUMP_CKSUM_EN
    logic [7:0] r_cksum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cksum <= 8'h00;
        end else if (r_state == S_SNAP) begin
            r_cksum <= reg_rd_data_i;
        end else if (r_state == S_SEND && w_load && !w_final) begin
            r_cksum <= r_cksum + reg_rd_data_i;
        end
    end

    assign w_byte = w_final ? r_cksum : reg_rd_data_i;
`else
    assign w_byte = reg_rd_data_i;
`endif

    // Byte 0 is loaded during SNAP: it is a default byte, unaffected by the
    // snapshot, and this gives first-valid two cycles after the start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: r_addr <= '0;
                S_SNAP, S_SEND: begin
                    if (w_load) begin
                        r_data  <= w_byte;
                        r_valid <= 1'b1;
                        r_last  <= w_final;
                        r_addr  <= r_addr + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (m_ready_i) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                    end
                end
                default: r_addr <= '0;
            endcase
        end
    end

    assign reg_rd_addr_o = r_addr[ADDR_WIDTH-1:0];
    assign reg_rd_en_o   = (r_state == S_SNAP);
    assign dump_busy_o   = (r_state != S_IDLE);
    assign dump_done_o   = r_done;
    assign m_data_o      = r_data;
    assign m_valid_o     = r_valid;
    assign m_last_o      = r_last;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// tb_regfile_dump : randomized self-checking bench for regfile_dump, with a
//                   register-file model and a queue-based expected stream.
// ============================================================================
module tb_regfile_dump;

    localparam int BYTE_CNT   = 16;
    localparam int ADDR_WIDTH = 4;
`ifdef REGFILE_DUMP_CKSUM_EN
    localparam int NB = BYTE_CNT + 1;
`else
    localparam int NB = BYTE_CNT;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_n_i;
    logic                  dump_start_i;
    logic                  dump_busy_o;
    logic                  dump_done_o;
    logic                  reg_rd_en_o;
    logic [ADDR_WIDTH-1:0] reg_rd_addr_o;
    logic [7:0]            reg_rd_data_i;
    logic [7:0]            m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    regfile_dump #(.BYTE_CNT(BYTE_CNT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .dump_start_i(dump_start_i),
        .dump_busy_o(dump_busy_o), .dump_done_o(dump_done_o),
        .reg_rd_en_o(reg_rd_en_o), .reg_rd_addr_o(reg_rd_addr_o),
        .reg_rd_data_i(reg_rd_data_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Register file: defaults in bytes 0..7, snapshot of the live config in 8..15
    logic [7:0]  def_b [8];
    logic [7:0]  snap_b[8];
    logic [63:0] reg_wr_data;

    always_comb begin
        reg_rd_data_i = reg_rd_addr_o[3] ? snap_b[reg_rd_addr_o[2:0]] : def_b[reg_rd_addr_o[2:0]];
    end

    initial begin
        for (int i = 0; i < 8; i++) snap_b[i] = 8'h00;
        forever begin
            @(negedge clk_i);
            if (reg_rd_en_o === 1'b1)
                for (int i = 0; i < 8; i++) snap_b[i] = reg_wr_data[8*i +: 8];
        end
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] byte_q[$];
    bit         last_q[$];
    int         done_cnt, done_cyc, rden_cnt, rden_cyc, first_valid_cyc;
    int         first_xfer_cyc, last_xfer_cyc, stall_err, start_cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    // Stream observer: records transfers, done pulses and stall stability
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_n_i !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last))
                    stall_err++;
                if (reg_rd_en_o === 1'b1) begin
                    if (rden_cnt == 0) rden_cyc = cyc;
                    rden_cnt++;
                end
                if (m_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
                    if (byte_q.size() == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    byte_q.push_back(m_data_o);
                    last_q.push_back(m_last_o);
                end
                if (dump_done_o === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = (m_valid_o === 1'b1) && (m_ready_i !== 1'b1);
                prev_data  = m_data_o;
                prev_last  = m_last_o;
            end
        end
    end

    // Expected stream: defaults, then config bytes, then optional sum
    function automatic void build_exp(input logic [63:0] wr);
        int sum;
        exp_q.delete();
        sum = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(def_b[i]);
        for (int i = 0; i < 8; i++) exp_q.push_back(wr[8*i +: 8]);
        for (int i = 0; i < BYTE_CNT; i++) sum += int'(exp_q[i]);
`ifdef REGFILE_DUMP_CKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endfunction

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    function automatic void clear_obs();
        byte_q.delete();
        last_q.delete();
        done_cnt = 0; rden_cnt = 0; stall_err = 0;
        first_valid_cyc = -1; done_cyc = -1; rden_cyc = -1;
        first_xfer_cyc = -1; last_xfer_cyc = -1;
    endfunction

    task automatic do_dump(input int mode, input int ra, input int rb,
                           input int rw_at, input logic [63:0] rw_val, output bit tmo);
        clear_obs();
        @(posedge clk_i); #1;
        start_cyc    = cyc;
        dump_start_i = 1'b1;
        m_ready_i    = rdy(mode, 0);
        tmo          = 1'b1;
        for (int k = 1; k < 400; k++) begin
            @(posedge clk_i); #1;
            dump_start_i = (k == ra) || (k == rb);
            if (k == rw_at) reg_wr_data = rw_val;
            m_ready_i = rdy(mode, k);
            if (done_cnt > 0) begin
                tmo = 1'b0;
                break;
            end
        end
        dump_start_i = 1'b0;
        m_ready_i    = 1'b1;
        repeat (25) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", m_valid_o); end
        n_tests++; if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b exp 0", m_last_o); end
        n_tests++; if (m_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", m_data_o); end
        n_tests++; if (reg_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_rden got %b exp 0", reg_rd_en_o); end
        n_tests++; if (reg_rd_addr_o !== 4'd0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", reg_rd_addr_o); end
        n_tests++; if (dump_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", dump_busy_o); end
        n_tests++; if (dump_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", dump_done_o); end
    endtask

    task automatic test_basic();
        bit tmo;
        reg_wr_data = 64'h0807060504030201;
        build_exp(reg_wr_data);
        do_dump(0, -1, -1, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL basic_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i] || last_q[i] !== (i == NB - 1)) begin
                n_fail++; $display("FAIL basic_byte[%0d] got %h/%0b exp %h/%0b", i, byte_q[i], last_q[i], exp_q[i], (i == NB - 1));
            end
        end
        n_tests++; if (rden_cnt != 1 || rden_cyc != start_cyc + 1) begin n_fail++; $display("FAIL basic_rden got cnt=%0d at=%0d exp cnt=1 at=%0d", rden_cnt, rden_cyc, start_cyc + 1); end
        n_tests++; if (first_valid_cyc != start_cyc + 2) begin n_fail++; $display("FAIL basic_first_valid got %0d exp %0d", first_valid_cyc, start_cyc + 2); end
        n_tests++; if (last_xfer_cyc - first_xfer_cyc != NB - 1) begin n_fail++; $display("FAIL basic_bubbles got span %0d exp %0d", last_xfer_cyc - first_xfer_cyc, NB - 1); end
        n_tests++; if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1) begin n_fail++; $display("FAIL basic_done got cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_cyc, last_xfer_cyc + 1); end
        n_tests++; if (dump_busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", dump_busy_o); end
    endtask

    task automatic test_stall();
        bit tmo;
        build_exp(reg_wr_data);
        do_dump(1, -1, -1, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL stall_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i] || last_q[i] !== (i == NB - 1)) begin
                n_fail++; $display("FAIL stall_byte[%0d] got %h/%0b exp %h/%0b", i, byte_q[i], last_q[i], exp_q[i], (i == NB - 1));
            end
        end
        n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stall_err); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_restart_ignored();
        bit tmo;
        build_exp(reg_wr_data);
        do_dump(0, 3, 10, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL restart_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_byte[%0d] got %h exp %h", i, byte_q[i], exp_q[i]); end
        end
        n_tests++; if (done_cnt != 1 || rden_cnt != 1) begin n_fail++; $display("FAIL restart_done got done=%0d rden=%0d exp 1/1", done_cnt, rden_cnt); end
    endtask

    task automatic test_rewrite();
        bit tmo;
        reg_wr_data = 64'h0807060504030201;
        build_exp(reg_wr_data);
        do_dump(0, -1, -1, 6, 64'hFFFF_FFFF_FFFF_FFFF, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL rewrite_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rewrite_byte[%0d] got %h exp %h", i, byte_q[i], exp_q[i]); end
        end
        build_exp(reg_wr_data);
        do_dump(2, -1, -1, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL rewrite2_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 8; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rewrite2_byte[%0d] got %h exp %h", i, byte_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        clear_obs();
        @(posedge clk_i); #1;
        dump_start_i = 1'b1;
        m_ready_i    = 1'b1;
        tmo          = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_i); #1;
            dump_start_i = 1'b0;
            if (byte_q.size() >= 5) begin tmo = 1'b0; break; end
        end
        n_tests++; if (tmo) begin n_fail++; $display("FAIL rstmid_reach got %0d bytes exp 5", byte_q.size()); end
        #2 rst_n_i = 1'b0;
        #1;
        n_tests++; if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_stream got v=%b l=%b d=%h exp 0/0/00", m_valid_o, m_last_o, m_data_o); end
        n_tests++; if (dump_busy_o !== 1'b0 || reg_rd_addr_o !== 4'd0 || reg_rd_en_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl got busy=%b addr=%h rden=%b exp 0/0/0", dump_busy_o, reg_rd_addr_o, reg_rd_en_o); end
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++; if (done_cnt != 0 || dump_done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone got %0d pulses exp 0", done_cnt); end
        build_exp(reg_wr_data);
        do_dump(0, -1, -1, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL rstmid_count got %0d exp %0d tmo=%0b", byte_q.size(), NB, tmo); end
        else for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (byte_q[i] !== exp_q[i] || last_q[i] !== (i == NB - 1)) begin
                n_fail++; $display("FAIL rstmid_byte[%0d] got %h/%0b exp %h/%0b", i, byte_q[i], last_q[i], exp_q[i], (i == NB - 1));
            end
        end
    endtask

    task automatic test_random();
        bit tmo;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) def_b[i] = 8'($urandom);
            reg_wr_data = {$urandom, $urandom};
            build_exp(reg_wr_data);
            do_dump(2, -1, -1, -1, 64'h0, tmo);
            n_tests++; if (tmo || byte_q.size() != NB) begin n_fail++; $display("FAIL rand%0d_count got %0d exp %0d tmo=%0b", it, byte_q.size(), NB, tmo); end
            else for (int i = 0; i < NB; i++) begin
                n_tests++;
                if (byte_q[i] !== exp_q[i] || last_q[i] !== (i == NB - 1)) begin
                    n_fail++; $display("FAIL rand%0d_byte[%0d] got %h/%0b exp %h/%0b", it, i, byte_q[i], last_q[i], exp_q[i], (i == NB - 1));
                end
            end
            n_tests++; if (stall_err != 0 || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_proto got unstable=%0d done=%0d exp 0/1", it, stall_err, done_cnt); end
        end
    endtask

`ifdef REGFILE_DUMP_CKSUM_EN
    task automatic test_cksum();
        bit tmo;
        for (int i = 0; i < 8; i++) def_b[i] = 8'h00;
        reg_wr_data = 64'h0807060504030201;
        do_dump(0, -1, -1, -1, 64'h0, tmo);
        n_tests++; if (tmo || byte_q.size() != BYTE_CNT + 1) begin n_fail++; $display("FAIL cksum_count got %0d exp %0d", byte_q.size(), BYTE_CNT + 1); end
        else begin
            n_tests++; if (byte_q[BYTE_CNT] !== 8'h24 || last_q[BYTE_CNT] !== 1'b1) begin
                n_fail++; $display("FAIL cksum_byte got %h/%0b exp 24/1", byte_q[BYTE_CNT], last_q[BYTE_CNT]); end
            n_tests++; if (last_q[BYTE_CNT-1] !== 1'b0) begin n_fail++; $display("FAIL cksum_b15_last got %0b exp 0", last_q[BYTE_CNT-1]); end
        end
    endtask
`endif

    initial begin
        rst_n_i      = 1'b0;
        dump_start_i = 1'b0;
        m_ready_i    = 1'b0;
        reg_wr_data  = 64'h0;
        for (int i = 0; i < 8; i++) def_b[i] = 8'hA0 + 8'(i * 7);
        clear_obs();
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        #3 rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_restart_ignored();
        test_rewrite();
        test_reset_mid();
        test_random();
`ifdef REGFILE_DUMP_CKSUM_EN
        test_cksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
